// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : IF->ID instruction fetch buffer. Holds {pc, instr} pairs in a
//               small circular store, presents the head show-ahead to decode,
//               back-pressures the PC register and flushes on redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter int          PTR_W    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  input  logic [31:0]      push_pc,
  input  logic [31:0]      push_instr,
  output logic             push_ready,
  output logic             pc_stall,
  output logic             pop_valid,
  output logic [31:0]      pop_pc,
  output logic [31:0]      pop_instr,
  input  logic             pop_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             overflow_err
);

  localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

  logic [31:0]      pc_mem_q    [DEPTH];
  logic [31:0]      instr_mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             w_push;
  logic             w_pop;

  // Handshake and status outputs; a full queue still accepts a push when the
  // head leaves in the same cycle, hence the pop_ready -> push_ready path.
  always_comb begin
    pop_valid    = (count_q != '0);
    w_pop        = pop_valid & pop_ready;
    push_ready   = (count_q < C_DEPTH) | w_pop;
    pc_stall     = ~push_ready;
    w_push       = push_valid & push_ready;
    pop_pc       = pop_valid ? pc_mem_q[rd_ptr_q]    : RESET_PC;
    pop_instr    = pop_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
    count        = count_q;
    overflow_err = overflow_q;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag; a
  // redirect overrides any push/pop pointer movement.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (push_valid & ~push_ready & ~flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage; pushes discarded by a flush are not written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else if (w_push && !flush) begin
      pc_mem_q[wr_ptr_q]    <= push_pc;
      instr_mem_q[wr_ptr_q] <= push_instr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue using a queue-based
//               behavioural model and randomized plus directed scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam int          PTR_W    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             push_valid = 1'b0;
  logic [31:0]      push_pc = '0;
  logic [31:0]      push_instr = '0;
  logic             pop_ready = 1'b0;
  logic             flush = 1'b0;
  logic             push_ready, pc_stall, pop_valid, overflow_err;
  logic [31:0]      pop_pc, pop_instr;
  logic [PTR_W:0]   count;

  logic [63:0] mq[$];
  bit          m_ovf = 1'b0;
  int          passed = 0;
  int          total  = 0;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .push_valid(push_valid), .push_pc(push_pc), .push_instr(push_instr),
    .push_ready(push_ready), .pc_stall(pc_stall),
    .pop_valid(pop_valid), .pop_pc(pop_pc), .pop_instr(pop_instr),
    .pop_ready(pop_ready), .flush(flush), .count(count),
    .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_pc();
    return (mq.size() != 0) ? mq[0][63:32] : RESET_PC;
  endfunction

  function automatic logic [31:0] exp_instr();
    return (mq.size() != 0) ? mq[0][31:0] : 32'h0;
  endfunction

  function automatic bit exp_ready();
    return (mq.size() < DEPTH) || ((mq.size() != 0) && pop_ready);
  endfunction

  // Apply the queue rules to the model with the inputs of this cycle, then
  // advance one clock and settle just after the edge.
  task automatic cycle();
    bit pv, pr;
    pv = (mq.size() != 0);
    pr = exp_ready();
    if (flush) mq.delete();
    else begin
      if (push_valid && !pr) m_ovf = 1'b1;
      if (pv && pop_ready) void'(mq.pop_front());
      if (push_valid && pr) mq.push_back({push_pc, push_instr});
    end
    @(posedge clk); #1;
  endtask

  task automatic drive_idle();
    push_valid = 1'b0; pop_ready = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; drive_idle();
    #12 reset = 1'b1;
    @(posedge clk); #1;
    total++; if (count !== 0 || pop_valid !== 1'b0) $display("FAIL reset_state count=%0d pop_valid=%b want 0/0", count, pop_valid); else passed++;
    total++; if (push_ready !== 1'b1 || pc_stall !== 1'b0 || overflow_err !== 1'b0) $display("FAIL reset_flags ready=%b stall=%b ovf=%b want 1/0/0", push_ready, pc_stall, overflow_err); else passed++;
    total++; if (pop_pc !== RESET_PC || pop_instr !== 32'h0) $display("FAIL reset_head pc=%h instr=%h want %h/0", pop_pc, pop_instr, RESET_PC); else passed++;
    for (int i = 0; i < 2; i++) begin
      push_valid = 1'b1; push_pc = 32'h3000 + 4*i; push_instr = $urandom;
      cycle();
    end
    push_valid = 1'b0;
    #1;
    total++; if (count !== 2) $display("FAIL pre_reset_count got=%0d want 2", count); else passed++;
    #2 reset = 1'b0;
    #1;
    mq.delete(); m_ovf = 1'b0;
    total++; if (count !== 0 || pop_valid !== 1'b0) $display("FAIL async_reset count=%0d pop_valid=%b want 0/0", count, pop_valid); else passed++;
    total++; if (pop_pc !== RESET_PC || pop_instr !== 32'h0) $display("FAIL async_reset_head pc=%h instr=%h want %h/0", pop_pc, pop_instr, RESET_PC); else passed++;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    total++; if (push_ready !== 1'b1 || pc_stall !== 1'b0) $display("FAIL reset_release ready=%b stall=%b want 1/0", push_ready, pc_stall); else passed++;
  endtask

  task automatic test_fill(output logic [31:0] first_word);
    first_word = $urandom;
    for (int i = 0; i < DEPTH; i++) begin
      push_valid = 1'b1; push_pc = 32'h3000 + 4*i;
      push_instr = (i == 0) ? first_word : $urandom;
      cycle();
    end
    push_valid = 1'b0;
    #1;
    total++; if (count !== 4) $display("FAIL fill_count got=%0d want 4", count); else passed++;
    total++; if (push_ready !== 1'b0 || pc_stall !== 1'b1) $display("FAIL fill_backpressure ready=%b stall=%b want 0/1", push_ready, pc_stall); else passed++;
    total++; if (pop_pc !== 32'h3000 || pop_instr !== first_word) $display("FAIL fill_head pc=%h instr=%h want 3000/%h", pop_pc, pop_instr, first_word); else passed++;
  endtask

  task automatic test_overflow();
    push_valid = 1'b1; push_pc = 32'h3099; push_instr = $urandom;
    #1;
    total++; if (push_ready !== 1'b0) $display("FAIL overflow_ready got=%b want 0", push_ready); else passed++;
    cycle();
    push_valid = 1'b0;
    #1;
    total++; if (count !== 4 || pop_pc !== 32'h3000) $display("FAIL overflow_ignored count=%0d head=%h want 4/3000", count, pop_pc); else passed++;
    total++; if (overflow_err !== 1'b1) $display("FAIL overflow_set got=%b want 1", overflow_err); else passed++;
    cycle();
    total++; if (overflow_err !== 1'b1) $display("FAIL overflow_sticky got=%b want 1", overflow_err); else passed++;
  endtask

  task automatic test_full_pushpop();
    logic [31:0] exp_seq [4];
    exp_seq = '{32'h3004, 32'h3008, 32'h300C, 32'h3010};
    pop_ready = 1'b1; push_valid = 1'b1; push_pc = 32'h3010; push_instr = $urandom;
    #1;
    total++; if (push_ready !== 1'b1 || count !== 4) $display("FAIL full_pushpop_ready ready=%b count=%0d want 1/4", push_ready, count); else passed++;
    cycle();
    push_valid = 1'b0; pop_ready = 1'b0;
    #1;
    total++; if (count !== 4 || pop_pc !== 32'h3004) $display("FAIL full_pushpop_after count=%0d head=%h want 4/3004", count, pop_pc); else passed++;
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (pop_valid !== 1'b1 || pop_pc !== exp_seq[i] || pop_instr !== exp_instr()) $display("FAIL drain_%0d pc=%h instr=%h want %h/%h", i, pop_pc, pop_instr, exp_seq[i], exp_instr()); else passed++;
      cycle();
    end
    pop_ready = 1'b0;
    #1;
    total++; if (count !== 0 || pop_valid !== 1'b0 || pop_pc !== RESET_PC) $display("FAIL drain_empty count=%0d valid=%b pc=%h want 0/0/%h", count, pop_valid, pop_pc, RESET_PC); else passed++;
  endtask

  task automatic test_wrap();
    int pops = 0;
    int pushes = 0;
    bit up = 1'b1;
    logic [31:0] pc = 32'h3100;
    for (int c = 0; c < 100 && pops < 10; c++) begin
      if (mq.size() >= 3) up = 1'b0;
      if (mq.size() <= 1) up = 1'b1;
      push_valid = up && (pushes < 11);
      pop_ready  = !up || (mq.size() == 0 ? 1'b0 : ($urandom_range(0, 1) == 1 && mq.size() > 1));
      push_pc = pc; push_instr = $urandom;
      #1;
      total++; if (count !== mq.size() || pop_pc !== exp_pc() || pop_instr !== exp_instr()) $display("FAIL wrap_cycle%0d count=%0d pc=%h instr=%h want %0d/%h/%h", c, count, pop_pc, pop_instr, mq.size(), exp_pc(), exp_instr()); else passed++;
      if (push_valid) begin pushes++; pc = pc + 4; end
      if (pop_ready && mq.size() != 0) pops++;
      cycle();
    end
    drive_idle();
    total++; if (pops < 10) $display("FAIL wrap_budget pops=%0d want 10", pops); else passed++;
  endtask

  task automatic test_flush();
    bit ovf_before;
    pop_ready = 1'b1;
    for (int i = 0; i < 8 && mq.size() != 0; i++) cycle();
    pop_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_valid = 1'b1; push_pc = 32'h3000 + 4*i; push_instr = $urandom;
      cycle();
    end
    ovf_before = m_ovf;
    flush = 1'b1; push_valid = 1'b1; push_pc = 32'h4000; push_instr = $urandom; pop_ready = 1'b1;
    #1;
    total++; if (pop_valid !== 1'b1 || pop_pc !== 32'h3000 || count !== 3) $display("FAIL flush_head valid=%b pc=%h count=%0d want 1/3000/3", pop_valid, pop_pc, count); else passed++;
    cycle();
    drive_idle();
    #1;
    total++; if (count !== 0 || pop_valid !== 1'b0) $display("FAIL flush_empty count=%0d valid=%b want 0/0", count, pop_valid); else passed++;
    total++; if (overflow_err !== ovf_before) $display("FAIL flush_ovf got=%b want %b", overflow_err, ovf_before); else passed++;
    push_valid = 1'b1; push_pc = 32'h5000; push_instr = 32'h1234_5678;
    #1;
    total++; if (pop_valid !== 1'b0) $display("FAIL no_fallthrough valid=%b want 0", pop_valid); else passed++;
    cycle();
    push_valid = 1'b0;
    #1;
    total++; if (pop_pc !== 32'h5000 || pop_instr !== 32'h1234_5678 || count !== 1) $display("FAIL post_flush_push pc=%h instr=%h count=%0d want 5000/12345678/1", pop_pc, pop_instr, count); else passed++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      push_valid = $urandom_range(0, 3) != 0;
      pop_ready  = $urandom_range(0, 2) == 0;
      flush      = $urandom_range(0, 19) == 0;
      push_pc    = $urandom; push_instr = $urandom;
      #1;
      total++;
      if (count !== mq.size() || pop_valid !== (mq.size() != 0) || pop_pc !== exp_pc() || pop_instr !== exp_instr() ||
          push_ready !== exp_ready() || pc_stall !== !exp_ready() || overflow_err !== m_ovf)
        $display("FAIL rand_cycle%0d count=%0d valid=%b pc=%h instr=%h ready=%b stall=%b ovf=%b want %0d/%b/%h/%h/%b/%b/%b",
                 c, count, pop_valid, pop_pc, pop_instr, push_ready, pc_stall, overflow_err,
                 mq.size(), mq.size() != 0, exp_pc(), exp_instr(), exp_ready(), !exp_ready(), m_ovf);
      else passed++;
      cycle();
    end
    drive_idle();
  endtask

  initial begin
    logic [31:0] first_word;
    test_reset();
    test_fill(first_word);
    test_overflow();
    test_full_pushpop();
    test_wrap();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
